// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be
// Simple dual-port synchronous RAM: one write port with per-byte enables and
// one read port. Read latency is 1 cycle, or 2 cycles with OUT_REG=1.
// RDW_MODE picks the result of a read that hits the word being written in
// the same cycle: 0 = old word, 1 = new word merged per byte.
//
// Ports:
//   clk      in   clock, all state changes on the rising edge
//   rst      in   asynchronous active-high reset (clears the read pipeline,
//                 leaves the memory array untouched)
//   wr_cs    in   write port select
//   wr_addr  in   write address (addresses >= DEPTH are ignored)
//   wr_data  in   write data
//   wr_be    in   byte enables, bit i covers wr_data[8i+7:8i]
//   rd_cs    in   read request
//   rd_addr  in   read address (addresses >= DEPTH read as zero)
//   rd_data  out  read data, holds between results
//   rd_valid out  one-cycle pulse per delivered read result
module dual_port_ram_be #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int OUT_REG    = 0,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_cs,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_cs,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  // One extra bit so DEPTH == 2^ADDR_WIDTH is representable and the range
  // compare never wraps.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  collision;
  logic [DATA_WIDTH-1:0] array_word;
  logic [DATA_WIDTH-1:0] read_word;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  // Range qualification for both ports. Out-of-range addresses never touch
  // the array, so there is no aliasing onto the low addresses.
  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < DEPTH_LIMIT);
    rd_in_range = ({1'b0, rd_addr} < DEPTH_LIMIT);
    collision   = wr_cs && rd_cs && wr_in_range && rd_in_range &&
                  (wr_addr == rd_addr);
  end

  // Array lookup for the read port. An out-of-range read returns zeros
  // instead of indexing past the end of the array.
  always_comb begin
    array_word = '0;
    if (rd_in_range) begin
      array_word = mem[rd_addr];
    end
  end

  // Collision resolution. In write-first mode the enabled bytes of the
  // incoming write replace the old bytes in the read result; in read-first
  // mode the old word passes through untouched.
  always_comb begin
    read_word = array_word;
    if ((RDW_MODE == 1) && collision) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_be[i]) begin
          read_word[8*i +: 8] = wr_data[8*i +: 8];
        end
      end
    end
  end

  // Write port and first read stage share one process so that reset
  // suppresses a write on an edge where rst is high. The memory array is
  // never cleared by reset. The first-stage data register only loads on a
  // request, which gives the hold behaviour when OUT_REG=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      if (wr_cs && wr_in_range) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (wr_be[i]) begin
            mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
          end
        end
      end
      s1_valid <= rd_cs;
      if (rd_cs) begin
        s1_data <= read_word;
      end
    end
  end

  // Optional output register. Its data only updates when the first stage
  // carries a result, so rd_data holds between reads in both latencies.
  generate
    if (OUT_REG == 1) begin : g_out_reg
      logic                  s2_valid;
      logic [DATA_WIDTH-1:0] s2_data;

      // Second pipeline stage: valid follows stage one, data is captured
      // only for real results.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign rd_valid = s2_valid;
      assign rd_data  = s2_data;
    end else begin : g_no_out_reg
      assign rd_valid = s1_valid;
      assign rd_data  = s1_data;
    end
  endgenerate

endmodule
